// File: rtl/ball_motion_pkg.sv
// Shared raster timing constants and ball-motion types.
// Defaults here set the 640x480 mode the sync counter runs in.
// Imported by ball_motion and its per-axis bounce sub-module.
package ball_motion_pkg;

    // Raster timing: totals per line/frame and the visible area.
    localparam int H_MAX         = 800;
    localparam int V_MAX         = 525;
    localparam int H_ACTIVE_DEF  = 640;
    localparam int V_ACTIVE_DEF  = 480;
    localparam int V_BLANK_START = V_ACTIVE_DEF;

    // Ball defaults: centred 16x16 square moving 2 px per frame.
    localparam int BALL_SIZE_DEF = 16;
    localparam int SPEED_DEF     = 2;
    localparam int X_START_DEF   = 312;
    localparam int Y_START_DEF   = 232;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_MOVE_X = 2'd1,
        ST_MOVE_Y = 2'd2,
        ST_HOLD   = 2'd3
    } motion_state_e;

    // True when lo <= pos < lo + size, all in 11 bits so the sum cannot wrap.
    function automatic logic in_span(input logic [10:0] pos,
                                     input logic [10:0] lo,
                                     input logic [10:0] size);
        return (pos >= lo) && (pos < (lo + size));
    endfunction

endpackage

// File: rtl/ball_motion_bounce_axis.sv
// bounce_axis: one axis of ball position plus direction, with wall clamp.
// Latency: position/direction update on the clock edge where i_En is high.
// No backpressure; i_En is a single-cycle strobe from the frame FSM.
module ball_motion_bounce_axis #(
    parameter int LIMIT = 624,
    parameter int SPEED = 2,
    parameter int START = 312
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_En,
    output logic [9:0] o_Pos,
    output logic       o_Dir
);

    localparam logic [10:0] LIM11   = 11'(LIMIT);
    localparam logic [10:0] SPD11   = 11'(SPEED);
    localparam logic [9:0]  LIM10   = 10'(LIMIT);
    localparam logic [9:0]  START10 = 10'(START);

    logic [9:0]  pos_q, pos_d;
    logic        dir_q, dir_d;   // 1 = moving +, 0 = moving -
    logic [10:0] pos_up;
    logic [10:0] pos_dn;

    // Next position: step by SPEED, clamp onto a wall and reverse on contact.
    always_comb begin
        pos_d  = pos_q;
        dir_d  = dir_q;
        pos_up = {1'b0, pos_q} + SPD11;
        pos_dn = {1'b0, pos_q} - SPD11;
        if (i_En) begin
            if (dir_q) begin
                if (pos_up >= LIM11) begin
                    pos_d = LIM10;
                    dir_d = 1'b0;
                end else begin
                    pos_d = pos_up[9:0];
                end
            end else begin
                if ({1'b0, pos_q} <= SPD11) begin
                    pos_d = '0;
                    dir_d = 1'b1;
                end else begin
                    pos_d = pos_dn[9:0];
                end
            end
        end
    end

    // Position and direction registers; reset puts the ball at START moving +.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            pos_q <= START10;
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign o_Pos = pos_q;
    assign o_Dir = dir_q;

endmodule

// File: rtl/ball_motion.sv
// Ball position tracker: one X then one Y step per frame at vblank start, plus pixel hit test.
// Latency: o_Draw 1 cycle after the raster sample; X moves 1 edge after trigger, Y 2 edges after.
// No backpressure; follows the free-running raster position from the sync counter.
module ball_motion
    import ball_motion_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_BLANK_START,
    parameter int BALL_SIZE = BALL_SIZE_DEF,
    parameter int SPEED     = SPEED_DEF,
    parameter int X_START   = X_START_DEF,
    parameter int Y_START   = Y_START_DEF
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_HPos,
    input  logic [9:0] i_VPos,
    output logic [9:0] o_BallX,
    output logic [9:0] o_BallY,
    output logic       o_Draw,
    output logic       o_FrameTick
);

    motion_state_e state_q, state_d;
    logic          tick_q, tick_d;
    logic          draw_q, draw_d;
    logic          trigger;
    logic [9:0]    ball_x, ball_y;
    logic          dir_x, dir_y;
    logic          unused_dir;

    assign trigger    = (i_HPos == 10'd0) && (i_VPos == 10'(V_ACTIVE));
    assign unused_dir = dir_x ^ dir_y;

    // Frame sequencer: wait for vblank start, step X, step Y, then hold until line 0.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT:   if (trigger) state_d = ST_MOVE_X;
            ST_MOVE_X: state_d = ST_MOVE_Y;
            ST_MOVE_Y: state_d = ST_HOLD;
            ST_HOLD:   if (i_VPos == 10'd0) state_d = ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
        tick_d = (state_d == ST_MOVE_X);
    end

    // Pixel hit test against the current ball square, limited to the visible area.
    always_comb begin
        draw_d = in_span({1'b0, i_HPos}, {1'b0, ball_x}, 11'(BALL_SIZE))
              && in_span({1'b0, i_VPos}, {1'b0, ball_y}, 11'(BALL_SIZE))
              && ({1'b0, i_HPos} < 11'(H_ACTIVE))
              && ({1'b0, i_VPos} < 11'(V_ACTIVE));
    end

    // State plus registered tick and draw outputs; reset aborts any update in flight.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= ST_WAIT;
            tick_q  <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            draw_q  <= draw_d;
        end
    end

    ball_motion_bounce_axis #(
        .LIMIT (H_ACTIVE - BALL_SIZE),
        .SPEED (SPEED),
        .START (X_START)
    ) u_axis_x (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_En    (state_q == ST_MOVE_X),
        .o_Pos   (ball_x),
        .o_Dir   (dir_x)
    );

    ball_motion_bounce_axis #(
        .LIMIT (V_ACTIVE - BALL_SIZE),
        .SPEED (SPEED),
        .START (Y_START)
    ) u_axis_y (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_En    (state_q == ST_MOVE_Y),
        .o_Pos   (ball_y),
        .o_Dir   (dir_y)
    );

    assign o_BallX     = ball_x;
    assign o_BallY     = ball_y;
    assign o_Draw      = draw_q;
    assign o_FrameTick = tick_q;

endmodule
